// File: rtl/fetch_ctl.sv
// ----------------------------------------------------------------------------
// fetch_ctl
//
// Front-end (IF/ID) pipeline control for a simple in-order core. Decides each
// cycle whether the PC advances, where the next PC comes from, and whether the
// IF/ID and ID/EX pipeline registers load, hold or take a NOP bubble. It also
// keeps two free-running performance counters.
//
// State | Meaning
// ------+---------------------------------------------------------------------
// RUN   | normal fetch; events arbitrated br_ctl > jump > hazard > halt > rdy
// DROP  | redirect issued while a fetch was outstanding; the next word the
//       | memory returns is wrong-path and is discarded
// HALT  | core stopped; only rst leaves this state
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   imem_rdy     in   instruction memory returns a valid word this cycle
//   hazard       in   load-use hazard on the ID-stage instruction
//   jump         in   ID-stage instruction is a jump
//   br_ctl       in   EX-stage branch resolved taken
//   halt         in   ID-stage instruction is HALT
//   pc_en        out  PC register write enable
//   redirect     out  PC source: 00 sequential, 01 jump, 10 branch
//   if_id_en     out  IF/ID register write enable
//   if_id_flush  out  load a NOP bubble into IF/ID
//   id_ex_flush  out  load a NOP bubble into ID/EX
//   halted       out  core halted
//   stall_cnt    out  front-end stall cycles, saturating
//   redir_cnt    out  taken redirects, wrapping
// ----------------------------------------------------------------------------
module fetch_ctl (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_rdy,
    input  logic        hazard,
    input  logic        jump,
    input  logic        br_ctl,
    input  logic        halt,
    output logic        pc_en,
    output logic [1:0]  redirect,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [7:0]  redir_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_DROP = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [1:0] RD_SEQ    = 2'b00;
    localparam logic [1:0] RD_JUMP   = 2'b01;
    localparam logic [1:0] RD_BRANCH = 2'b10;

    state_t state;
    state_t state_nxt;
    logic   stall_inc;
    logic   redir_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_en       = 1'b0;
        redirect    = RD_SEQ;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = 1'b0;

        case (state)
            ST_RUN: begin
                if (br_ctl) begin
                    // Branch wins over a simultaneous jump: the jump sits in
                    // ID on the wrong path and is squashed with the bubble.
                    pc_en       = 1'b1;
                    redirect    = RD_BRANCH;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (!imem_rdy) begin
                        state_nxt = ST_DROP;
                    end
                end else if (jump) begin
                    pc_en       = 1'b1;
                    redirect    = RD_JUMP;
                    if_id_flush = 1'b1;
                    if (!imem_rdy) begin
                        state_nxt = ST_DROP;
                    end
                end else if (hazard) begin
                    id_ex_flush = 1'b1;
                end else if (halt) begin
                    state_nxt = ST_HALT;
                end else if (!imem_rdy) begin
                    if_id_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                end
            end

            ST_DROP: begin
                // The in-flight fetch belongs to the old path; when it lands
                // it is flushed and sequential fetch from the new PC resumes.
                if_id_flush = 1'b1;
                if (imem_rdy) begin
                    state_nxt = ST_RUN;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                // Unreachable encoding: bubble both stages and restart.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_nxt   = ST_RUN;
            end
        endcase

        // Reset holds the pipeline in a safe, fully flushed condition.
        if (rst) begin
            state_nxt   = ST_RUN;
            pc_en       = 1'b0;
            redirect    = RD_SEQ;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            halted      = 1'b0;
        end
    end

    assign stall_inc = ((state == ST_RUN) || (state == ST_DROP)) && !pc_en;
    assign redir_inc = (redirect != RD_SEQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if (stall_inc && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_cnt <= 8'h00;
        end else if (redir_inc) begin
            redir_cnt <= redir_cnt + 8'd1;
        end
    end

endmodule
